// File: rtl/store_pkg.sv
// Shared definitions for the store path: funct3 encodings, FSM states and the
// byte-strobe helper used for both accept-time checks and lane formation.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT2 = 2'd3,
    ST_BEAT1 = 2'd2
  } state_e;

  // Byte strobes of a store of the given width, shifted to lane 'off'. The
  // result is two words wide (up to 8 lanes each) so that any bytes spilling
  // past the first word land in the upper half.
  function automatic logic [15:0] lane_strobe(input logic [2:0] funct3,
                                              input logic [2:0] off);
    logic [15:0] m;
    m = 16'h0000;
    if (!funct3[2]) begin
      unique case (funct3[1:0])
        2'd0: m = 16'h0001;
        2'd1: m = 16'h0003;
        2'd2: m = 16'h000F;
        2'd3: m = 16'h00FF;
      endcase
    end
    return m << off;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous request FIFO with full/empty/count status. Storage is
// not reset; only pointers and occupancy are.
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store path from execute to the data-memory write port: legality checks,
// request FIFO, byte-lane alignment and a valid/ready beat FSM.
// Optional: define STORE_MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_unit
  import store_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic              misalign_exc,
  output logic              illegal_exc,
  output logic              busy
);

  localparam int NB    = XLEN / 8;
  localparam int OFF   = $clog2(NB);
  localparam int ENT_W = ADDR_W + XLEN + 3;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              rdy_en_q;
  logic              illegal_q, misal_q, misal_d;
  logic              accept, req_illegal, push, pop, more;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;

  // req_ready is held low until the first clock after reset release.
  assign req_ready   = rdy_en_q && !full;
  assign accept      = req_valid && req_ready;
  assign req_illegal = req_funct3[2] || ((req_funct3 == F3_SD) && (XLEN == 32));

`ifdef STORE_MISALIGN_SPLIT_EN
  assign push    = accept && !req_illegal;
  assign misal_d = 1'b0;
`else
  logic [3:0] req_off, req_size;
  logic       req_misal;

  assign req_off   = 4'(req_addr[OFF-1:0]);
  assign req_size  = 4'd1 << req_funct3[1:0];
  assign req_misal = ((req_off + req_size) > 4'(NB)) ||
                     ((req_off & (req_size - 4'd1)) != 4'd0);
  assign push      = accept && !req_illegal && !req_misal;
  assign misal_d   = accept && !req_illegal && req_misal;
`endif

  store_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({req_addr, req_wdata, req_funct3}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  logic [ADDR_W-1:0] h_addr, base_addr, beat_addr;
  logic [XLEN-1:0]   h_wdata, h_data_m, data_mask, beat_wdata;
  logic [2:0]        h_funct3, h_off3;
  logic [OFF-1:0]    h_off;
  logic [NB-1:0]     size_bytes, beat_strb;

  assign {h_addr, h_wdata, h_funct3} = head;
  assign h_off      = h_addr[OFF-1:0];
  assign h_off3     = 3'(h_off);
  assign base_addr  = {h_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign size_bytes = NB'(lane_strobe(h_funct3, 3'd0));

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < XLEN; i++) data_mask[i] = size_bytes[i/8];
  end

  assign h_data_m = h_wdata & data_mask;

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [2*XLEN-1:0] wide;
  logic [2*NB-1:0]   strb_full;
  logic              split_need, in_beat1;

  // Shift into a double-width word; the upper half is the second beat.
  assign wide       = {{XLEN{1'b0}}, h_data_m} << {h_off, 3'b000};
  assign strb_full  = (2*NB)'(lane_strobe(h_funct3, h_off3));
  assign split_need = |strb_full[2*NB-1:NB];
  assign in_beat1   = (state_q == ST_BEAT1);
  assign beat_addr  = in_beat1 ? base_addr + ADDR_W'(NB) : base_addr;
  assign beat_wdata = in_beat1 ? wide[2*XLEN-1:XLEN] : wide[XLEN-1:0];
  assign beat_strb  = in_beat1 ? strb_full[2*NB-1:NB] : strb_full[NB-1:0];
`else
  assign beat_addr  = base_addr;
  assign beat_wdata = h_data_m << {h_off, 3'b000};
  assign beat_strb  = NB'(lane_strobe(h_funct3, h_off3));
`endif

  // A concurrent accept counts as a remaining entry so beats stay back-to-back.
  assign more = (count > CNT_W'(1)) || push;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_BEAT0;
      end
      ST_BEAT0: begin
        if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
          if (split_need) begin
            state_d = ST_BEAT1;
          end else begin
            pop     = 1'b1;
            state_d = more ? ST_BEAT0 : ST_IDLE;
          end
`else
          pop     = 1'b1;
          state_d = more ? ST_BEAT0 : ST_IDLE;
`endif
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        if (mem_ready) begin
          pop     = 1'b1;
          state_d = more ? ST_BEAT0 : ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      illegal_q <= 1'b0;
      misal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      illegal_q <= accept && req_illegal;
      misal_q   <= misal_d;
    end
  end

  assign mem_valid    = (state_q != ST_IDLE);
  assign mem_addr     = mem_valid ? beat_addr  : '0;
  assign mem_wdata    = mem_valid ? beat_wdata : '0;
  assign mem_wstrb    = mem_valid ? beat_strb  : '0;
  assign misalign_exc = misal_q;
  assign illegal_exc  = illegal_q;
  assign busy         = (count != '0) || (state_q != ST_IDLE);

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Parametrised store path between the execute stage and the data-memory write port.
- Replaces the plain combinational store truncation with:
  - a small request FIFO;
  - byte-lane alignment and write-strobe generation;
  - alignment and funct3 legality checks;
  - a valid/ready handshake to memory.
- Sits after the ALU address calculation and drives the data-memory write bus.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- DEPTH, 2: request FIFO entries; power of two, at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  FIFO can accept a request
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  unaligned store data, low bytes significant
- req_funct3  in  3  width: 000 SB, 001 SH, 010 SW, 011 SD (legal only when XLEN=64)
- mem_valid  out  1  memory write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero)
- mem_wdata  out  XLEN  lane-shifted data
- mem_wstrb  out  XLEN/8  byte strobes
- misalign_exc  out  1  one-cycle pulse on misaligned store
- illegal_exc  out  1  one-cycle pulse on illegal funct3
- busy  out  1  FIFO non-empty or beat in flight

Behaviour:
- Reset:
  - Asynchronous, active-low: rst_n low acts immediately, independent of clk.
  - FIFO empty, FSM IDLE, all outputs 0. req_ready goes to 1 on the first cycle after deassertion.
  - Reset mid-beat drops all pending stores; no partial beat is re-issued.
- Accept rule:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready = !full. A simultaneous push and pop while full is not allowed; ready stays low.
- Legality, checked at accept, with OFF = log2(XLEN/8):
  - size = 1 << funct3[1:0].
  - Misaligned when addr[OFF-1:0] + size > XLEN/8, or for SH/SW/SD when addr is not size-aligned.
  - Illegal funct3: the entry is not enqueued, and illegal_exc pulses the next cycle.
  - Misaligned, without the optional feature: not enqueued, and misalign_exc pulses the next cycle.
- Lane formation:
  - off = addr[OFF-1:0].
  - mem_wdata = (wdata masked to size) << (8*off).
  - mem_wstrb = ((1<<size)-1) << off, truncated to XLEN/8.
  - mem_addr = addr with low OFF bits cleared.
- FSM states:
  - IDLE: FIFO empty; mem_valid = 0.
  - BEAT0: head entry presented on mem_*; mem_valid = 1.
  - BEAT1: second beat of a split store (feature only).
- Transitions:
  - IDLE -> BEAT0 on the cycle after the FIFO becomes non-empty (1-cycle latency from accept to mem_valid).
  - BEAT0 with mem_ready: pop, then go to BEAT0 if more entries remain, else IDLE; back-to-back beats are allowed.
  - BEAT0 with mem_ready and split needed: go to BEAT1 without popping.
  - BEAT1 with mem_ready: pop, then go to BEAT0 or IDLE as above.
- mem_* outputs are held stable while mem_valid && !mem_ready.
- Pointers wrap modulo DEPTH; count has width log2(DEPTH)+1.
- busy = (count != 0) || state != IDLE.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned stores that cross a word boundary are enqueued and split into two beats.
  - BEAT0 carries the low bytes at the base word; strobes are those of the full store shifted by off and truncated to XLEN/8.
  - BEAT1 carries the remaining bytes at base + XLEN/8; lanes start at lane 0; strobes are the overflow bits.
  - misalign_exc stays 0 for these stores.
  - Misaligned stores that do not cross a word boundary (e.g. SW at off=1 with XLEN=64) stay in one beat.
- Undefined:
  - The BEAT1 state and logic are absent.
  - Every misaligned store is dropped with a misalign_exc pulse.

Decomposition:
- Shared package store_pkg:
  - funct3 constants SB/SH/SW/SD;
  - FSM state enum;
  - size/strobe helper function.
- One sub-module, store_fifo: a generic DEPTH x (ADDR_W+XLEN+3) synchronous FIFO with full/empty/count outputs.

Test Plan:
1. XLEN=32. SB, addr=0x1003, wdata=0xAABBCCDD, mem_ready=1 -> one beat next cycle: mem_addr=0x1000, wdata=0xDD000000, wstrb=1000.
2. SH at addr=0x2002, data=0x1234 -> wdata=0x12340000, wstrb=1100.
3. SH at addr=0x2001:
   - Without the macro: misalign_exc pulses once, no beat, busy stays 0.
   - With the macro, SW 0x11223344 at addr=0x3003: beats at 0x3000 (wdata 0x44000000, strb 1000) and 0x3004 (wdata 0x00112233, strb 0111).
4. funct3=011 with XLEN=32 -> illegal_exc pulses, nothing enqueued.
5. DEPTH=2. Three back-to-back SW with mem_ready=0:
   - req_ready drops after the second accept.
   - mem_* stay stable.
   - Raising mem_ready drains the stores in order, one per cycle.
6. Assert rst_n low while a beat is stalled -> mem_valid goes to 0 immediately, busy=0, FIFO empty after release.
